// File: rtl/fifo_burst_reader.sv
// Read-side master for the register FIFO: drains entries in bursts of up to
// BURST beats onto a registered valid/ready stream, tagging each burst's final beat.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for BURST entries, or for the timer to flush a partial burst
// RUN   | popping the latched burst remainder, one beat per accepted slot
module fifo_burst_reader #(
   parameter int ENTRY_WD = 32,
   parameter int LEN_WD   = 4,
   parameter int BURST    = 4,
   parameter int TIMEOUT  = 15,
   parameter int TO_WD    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_empty,
   input  logic [LEN_WD-1:0]   fifo_len,
   input  logic [ENTRY_WD-1:0] fifo_data,
   output logic                fifo_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ENTRY_WD-1:0] out_data,
   output logic                out_last,
   output logic                busy
);

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   localparam logic [LEN_WD-1:0] BURST_LEN = LEN_WD'(BURST);
   localparam logic [TO_WD-1:0]  TO_VAL    = TO_WD'(TIMEOUT);

   state_t            state, state_nxt;
   logic [TO_WD-1:0]  timer, timer_nxt;
   logic [LEN_WD-1:0] rem, rem_nxt;
   logic              take;
   logic              len_full;
   logic              timed_out;

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      rem_nxt   = rem;
      take      = 1'b0;
      len_full  = (fifo_len >= BURST_LEN);
      timed_out = (timer == TO_VAL);
      case (state)
         IDLE: begin
            if (fifo_empty) begin
               timer_nxt = '0;
            end else if (len_full || timed_out) begin
               state_nxt = RUN;
               timer_nxt = '0;
               rem_nxt   = len_full ? BURST_LEN : fifo_len;
            end else begin
               timer_nxt = timer + TO_WD'(1);
            end
         end
         RUN: begin
            // rst gate keeps a mid-burst reset from popping an entry
            take = !rst && !fifo_empty && (rem != '0) && (!out_valid || out_ready);
            if (take) begin
               rem_nxt = rem - LEN_WD'(1);
               if (rem == LEN_WD'(1)) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         rem   <= rem_nxt;
         if (take) begin
            out_data  <= fifo_data;
            out_valid <= 1'b1;
            out_last  <= (rem == LEN_WD'(1));
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   assign fifo_rd = take;
   assign busy    = (state == RUN) || out_valid;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, transaction-level burst model
// feeding a scoreboard, directed scenarios followed by randomized traffic.
module tb_fifo_burst_reader;

   localparam int ENTRY_WD = 32;
   localparam int LEN_WD   = 4;
   localparam int BURST    = 4;
   localparam int TIMEOUT  = 15;
   localparam int TO_WD    = 4;
   localparam int FIFO_MAX = 15;

   logic                clk;
   logic                rst;
   logic                fifo_empty;
   logic [LEN_WD-1:0]   fifo_len;
   logic [ENTRY_WD-1:0] fifo_data;
   logic                fifo_rd;
   logic                out_valid;
   logic                out_ready;
   logic [ENTRY_WD-1:0] out_data;
   logic                out_last;
   logic                busy;

   fifo_burst_reader #(
      .ENTRY_WD(ENTRY_WD), .LEN_WD(LEN_WD), .BURST(BURST),
      .TIMEOUT(TIMEOUT), .TO_WD(TO_WD)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_empty(fifo_empty), .fifo_len(fifo_len), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_beats  = 0;
   int n_lasts  = 0;

   logic [ENTRY_WD-1:0] fq[$];
   logic [ENTRY_WD:0]   exp_q[$];
   logic                rd_pending = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic drive_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_len   = LEN_WD'(fq.size());
      fifo_data  = (fq.size() == 0) ? '0 : fq[0];
   endtask

   // Inputs change only at negedge; pops seen before the posedge are applied here.
   task automatic tick();
      @(negedge clk);
      if (rd_pending && fq.size() != 0) fq.delete(0);
      rd_pending = 1'b0;
      if (rst) fq.delete();
      drive_fifo();
   endtask

   task automatic push(logic [ENTRY_WD-1:0] v);
      if (fq.size() < FIFO_MAX) fq.push_back(v);
      drive_fifo();
   endtask

   task automatic do_reset(int cycles);
      rst = 1'b1;
      fq.delete();
      drive_fifo();
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(int bound);
      int k = 0;
      #1;
      while (!out_valid && k < bound) begin
         tick();
         #1;
         k++;
      end
      chk("wait_valid", 64'(out_valid), 64'(1));
   endtask

   task automatic drain(int bound);
      int k = 0;
      out_ready = 1'b1;
      #1;
      while ((busy || fq.size() != 0) && k < bound) begin
         tick();
         #1;
         k++;
      end
      chk("drain_idle", 64'(busy || fq.size() != 0), 64'(0));
   endtask

   // Reference model: abstract burst bookkeeping sampled after inputs settle.
   bit m_run  = 0;
   bit m_slot = 0;
   int m_left = 0;
   int m_wait = 0;

   always @(negedge clk) begin
      int  avail;
      bit  m_take;
      #2;
      if (rst) begin
         chk("rd_in_rst", 64'(fifo_rd), 64'(0));
         m_run = 0; m_slot = 0; m_left = 0; m_wait = 0;
         exp_q.delete();
         rd_pending = 1'b0;
      end else begin
         avail  = fq.size();
         m_take = m_run && avail > 0 && m_left > 0 && (!m_slot || out_ready);
         chk("fifo_rd", 64'(fifo_rd), 64'(m_take));
         chk("out_valid", 64'(out_valid), 64'(m_slot));
         chk("busy", 64'(busy), 64'(m_run || m_slot));
         rd_pending = fifo_rd;
         if (!m_run) begin
            if (avail == 0) begin
               m_wait = 0;
            end else if (avail >= BURST || m_wait == TIMEOUT) begin
               m_run  = 1;
               m_left = (avail >= BURST) ? BURST : avail;
               m_wait = 0;
            end else begin
               m_wait++;
            end
         end else if (m_take) begin
            exp_q.push_back({(m_left == 1), fq[0]});
            m_left--;
            if (m_left == 0) m_run = 0;
         end
         if (m_take) m_slot = 1;
         else if (m_slot && out_ready) m_slot = 0;
      end
   end

   // Monitor: every accepted beat must match the next expected beat.
   always @(negedge clk) begin
      logic [ENTRY_WD:0] e;
      #3;
      if (!rst && out_valid && out_ready) begin
         n_beats++;
         if (out_last) n_lasts++;
         if (exp_q.size() == 0) begin
            chk("beat_unexpected", 64'(out_data), 64'(0));
            n_checks++;
            n_fail++;
            $display("FAIL beat_unexpected: got beat %0h expected none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(out_data), 64'(e[ENTRY_WD-1:0]));
            chk("beat_last", 64'(out_last), 64'(e[ENTRY_WD]));
         end
      end
   end

   initial begin
      int b0, l0;
      rst = 1'b1;
      out_ready = 1'b0;
      drive_fifo();

      // reset state
      do_reset(2);
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_rd", 64'(fifo_rd), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      rst = 1'b0;
      tick();

      // full burst, continuous ready
      b0 = n_beats; l0 = n_lasts;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("full_rd_run", 64'(fifo_rd), 64'(1));
         tick();
      end
      #1;
      chk("full_rd_end", 64'(fifo_rd), 64'(0));
      drain(20);
      chk("full_beats", 64'(n_beats - b0), 64'(4));
      chk("full_lasts", 64'(n_lasts - l0), 64'(1));

      // partial burst flushed by timeout
      b0 = n_beats; l0 = n_lasts;
      push(32'hB0);
      push(32'hB1);
      for (int i = 0; i <= TIMEOUT; i++) begin
         #1;
         chk("to_wait_rd", 64'(fifo_rd), 64'(0));
         tick();
      end
      #1;
      chk("to_flush_rd", 64'(fifo_rd), 64'(1));
      drain(20);
      chk("to_beats", 64'(n_beats - b0), 64'(2));
      chk("to_lasts", 64'(n_lasts - l0), 64'(1));

      // backpressure stall after beat 1
      b0 = n_beats; l0 = n_lasts;
      for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
      wait_valid(6);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("stall_data", 64'(out_data), 64'(32'hC0));
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_rd", 64'(fifo_rd), 64'(0));
      end
      drain(20);
      chk("stall_beats", 64'(n_beats - b0), 64'(4));
      chk("stall_lasts", 64'(n_lasts - l0), 64'(1));

      // 9 entries: 4 + 4, then a timed-out single beat
      b0 = n_beats; l0 = n_lasts;
      for (int i = 0; i < 9; i++) push(32'hE0 + 32'(i));
      drain(80);
      chk("nine_beats", 64'(n_beats - b0), 64'(9));
      chk("nine_lasts", 64'(n_lasts - l0), 64'(3));

      // reset mid-burst on beat 2
      for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
      wait_valid(6);
      tick();
      rst = 1'b1;
      fq.delete();
      drive_fifo();
      tick();
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_rd", 64'(fifo_rd), 64'(0));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("post_rst_rd", 64'(fifo_rd), 64'(0));
      end

      // randomized traffic with backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) push($urandom);
         if ($urandom_range(0, 799) == 0) do_reset(1);
         else tick();
      end
      drain(100);
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
